bcd_column_streamer: RTL
========================

// Module: bcd_column_streamer
// PURPOSE
//  Renders an NUM_DIGITS-digit BCD value into 32-bit matrix column words, MS digit first.
//  Streams the columns to the frame-buffer writer over a valid/ready handshake.
//  Supports per-digit colour, leading-zero blanking, a wrapping start column and abort.
//  Sits between the counter/score logic and the 32x16 frame buffer.
// PARAMETERS
//  NUM_DIGITS  4   digits rendered per request (1..8)
//  GLYPH_COLS  6   columns per digit; cols 0..4 = font, cols 5..GLYPH_COLS-1 blank (5..8)
//  DISP_COLS   32  frame-buffer width; col_addr wraps modulo DISP_COLS (power of 2)
// PORTS
//  clk          in   1                 system clock
//  rst_n        in   1                 asynchronous active-low reset
//  start        in   1                 request; accepted only when busy==0
//  abort        in   1                 terminate the current stream
//  digits       in   4*NUM_DIGITS      BCD value; [3:0] is the LS digit
//  digit_color  in   3*NUM_DIGITS      {R,G,B} per digit; [2:0] is the LS digit
//  blank_lz     in   1                 blank leading zeros (LS digit never blanked)
//  base_col     in   $clog2(DISP_COLS) frame column of the first emitted column
//  col_ready    in   1                 sink accepts col_data this cycle
//  col_valid    out  1                 col_data/col_addr are valid
//  col_data     out  32                8 nibbles {1'b0,R,G,B}; bit[3:0] = bottom pixel
//  col_addr     out  $clog2(DISP_COLS) destination column
//  busy         out  1                 a stream is in progress
//  done         out  1                 one-cycle pulse after the last column handshake
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, internal capture registers 0. Reset mid-stream drops col_valid immediately.
//  - FSM states:
//    - IDLE: start -> STREAM. digits, digit_color, blank_lz and base_col are captured at that edge.
//    - STREAM: col_valid=1, busy=1. The edge where col_valid&col_ready advances the column index.
//      The last handshake (index NUM_DIGITS*GLYPH_COLS-1) -> DONE.
//    - DONE: done=1, busy=0, col_valid=0 for exactly one cycle -> IDLE. A start in DONE is accepted (-> STREAM).
//  - Latency: start sampled at edge k. col_valid is high, with column 0, from edge k to k+1.
//    With col_ready tied high, NUM_DIGITS*GLYPH_COLS consecutive columns follow; done is high for the cycle after the last one.
//  - Handshake: while col_valid && !col_ready, col_data and col_addr hold stable. No column is skipped or repeated.
//  - All outputs are registered. The next column is precomputed so back-to-back handshakes sustain 1 column/cycle.
//  - Column index i: digit d = NUM_DIGITS-1 - i/GLYPH_COLS, glyph column c = i%GLYPH_COLS.
//    Use a digit counter plus a column counter, not a divider.
//  - col_addr = (base_col + i) mod DISP_COLS, so the stream wraps past the right edge.
//  - col_data = glyph(d,c) & {8{1'b0,digit_color[d]}}. Columns c>=5 emit 0.
//  - Invalid BCD (>9) renders the error glyph in that digit's colour. The error glyph counts as non-zero for blanking.
//  - Leading-zero blanking: with blank_lz=1, digits left of the first non-zero digit emit all-zero columns.
//    The addresses of blanked columns still advance. Digit 0 is always drawn.
//  - start while busy: ignored; captured registers are unchanged.
//  - abort (any state, priority over start and handshake): next state IDLE, col_valid=0 and busy=0 from the next edge, no done pulse.
//  - start and abort together in IDLE: abort wins, nothing is started.
// STRUCTURE
//  - Package led_matrix_pkg: col_word_t (logic [31:0]), rgb_t (logic [2:0]), FONT_COLS=5,
//    the glyph table localparam [0:10][0:4] col_word_t (digits 0-9, index 10 = error), and a state enum.
//  - Sub-module glyph_col_rom (combinational: num[3:0], col[2:0] -> col_word_t white).
//    It maps nums >9 to the error glyph and cols >=FONT_COLS to 0.
//  - The colour mask and output registers live in bcd_column_streamer.
// TESTING
//  1. digits=16'h1234, all colours 3'b010, base_col=0, ready=1 -> 24 columns at addr 0..23.
//     Column 2 = 32'h22222222. Columns 5,11,17,23 = 0. done one cycle after the last column.
//  2. digits=16'h0045, blank_lz=1 -> columns 0..11 = 0 with addr 0..11. The '4' and '5' glyphs follow.
//     digits=16'h0000 -> only the last 6 columns show '0'.
//  3. Random col_ready (~40% duty) on test 1 -> data/addr are held while stalled. The sequence is identical to test 1, 24 handshakes.
//  4. base_col=28, DISP_COLS=32 -> col_addr 28,29,30,31,0..19. Digit 2=4'hA -> error glyph masked by its colour.
//  5. abort asserted at the 7th handshake -> col_valid=0 and busy=0 on the next edge, no done.
//     start in the following cycle restarts from column 0.
//  6. rst_n low mid-stream (asynchronous, between edges) -> all outputs 0 immediately.
//     start during busy is ignored; start in the DONE cycle is accepted.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared types, font table and FSM states
// for the LED matrix column datapath.
package led_matrix_pkg;

  typedef logic [31:0] col_word_t;
  typedef logic [2:0]  rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  localparam int FONT_COLS = 5;
  localparam int ERR_GLYPH = 10;

  // White 5x8 glyphs: nibble 0 is the bottom pixel,
  // a lit pixel is 4'h7 so a colour mask selects R/G/B.
  localparam col_word_t GLYPH_ROM [0:10][0:4] = '{
    '{32'h07777770, 32'h70000007, 32'h70000007,
      32'h70000007, 32'h07777770},
    '{32'h00000000, 32'h07000007, 32'h77777777,
      32'h00000007, 32'h00000000},
    '{32'h07000077, 32'h70000707, 32'h70007007,
      32'h70070007, 32'h07700007},
    '{32'h07000070, 32'h70000007, 32'h70070007,
      32'h70070007, 32'h07707770},
    '{32'h00077000, 32'h00707000, 32'h07007000,
      32'h77777777, 32'h00007000},
    '{32'h77770070, 32'h70070007, 32'h70070007,
      32'h70070007, 32'h70007770},
    '{32'h07777770, 32'h70070007, 32'h70070007,
      32'h70070007, 32'h07007770},
    '{32'h70000000, 32'h70000777, 32'h70007000,
      32'h70070000, 32'h77700000},
    '{32'h07707770, 32'h70070007, 32'h70070007,
      32'h70070007, 32'h07707770},
    '{32'h07770070, 32'h70007007, 32'h70007007,
      32'h70007007, 32'h07777770},
    '{32'h77777777, 32'h70070007, 32'h70070007,
      32'h70070007, 32'h70000007}
  };

endpackage

// File: rtl/glyph_col_rom.sv
// White glyph column lookup; non-BCD values
// map to the error glyph, spacing columns are dark.
module glyph_col_rom
  import led_matrix_pkg::*;
(
  input  logic [3:0] num,
  input  logic [2:0] col,
  output col_word_t  word
);

  logic [3:0] idx;

  // Select glyph row, blank the inter-digit gap
  always_comb begin
    idx  = (num > 4'd9) ? 4'(ERR_GLYPH) : num;
    word = '0;
    if (col < 3'(FONT_COLS))
      word = GLYPH_ROM[idx][col];
  end

endmodule

// File: rtl/bcd_column_streamer.sv
// Streams a coloured BCD readout as matrix
// columns, MS digit first, over valid/ready.
module bcd_column_streamer
  import led_matrix_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int GLYPH_COLS = 6,
  parameter int DISP_COLS  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [4*NUM_DIGITS-1:0]      digits,
  input  logic [3*NUM_DIGITS-1:0]      digit_color,
  input  logic                         blank_lz,
  input  logic [$clog2(DISP_COLS)-1:0] base_col,
  input  logic                         col_ready,
  output logic                         col_valid,
  output logic [31:0]                  col_data,
  output logic [$clog2(DISP_COLS)-1:0] col_addr,
  output logic                         busy,
  output logic                         done
);

  localparam int DW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int AW = $clog2(DISP_COLS);
  localparam logic [DW-1:0] MS_DIG =
    DW'(NUM_DIGITS - 1);
  localparam logic [2:0] LAST_COL =
    3'(GLYPH_COLS - 1);

  state_t state, state_n;

  logic [4*NUM_DIGITS-1:0] dig_q, src_dig;
  logic [3*NUM_DIGITS-1:0] rgb_q, src_rgb;
  logic                    blank_q, src_blank;

  logic [DW-1:0] d_q, d_n;
  logic [2:0]    c_q, c_n;
  logic          load, step, hs;

  logic [3:0] num;
  rgb_t       rgb;
  logic       lz;
  col_word_t  white, word_n;

  assign hs = col_valid & col_ready;

  // Next state and position of the column
  // to be presented after this edge
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    d_n     = d_q;
    c_n     = c_q;
    if (abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          state_n = IDLE;
          if (start) begin
            state_n = STREAM;
            load    = 1'b1;
            d_n     = MS_DIG;
            c_n     = '0;
          end
        end
        STREAM: begin
          if (hs) begin
            if (d_q == '0 && c_q == LAST_COL) begin
              state_n = DONE;
            end else begin
              step = 1'b1;
              if (c_q == LAST_COL) begin
                d_n = d_q - DW'(1);
                c_n = '0;
              end else begin
                c_n = c_q + 3'd1;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Precompute the next column word from the
  // live inputs on start, captured copy otherwise
  always_comb begin
    src_dig   = load ? digits      : dig_q;
    src_rgb   = load ? digit_color : rgb_q;
    src_blank = load ? blank_lz    : blank_q;
    num       = src_dig[4*d_n +: 4];
    rgb       = src_rgb[3*d_n +: 3];
    lz        = src_blank && (d_n != '0) &&
                ((src_dig >> (4*d_n)) == '0);
    word_n    = lz ? '0 :
                (white & {8{1'b0, rgb}});
  end

  glyph_col_rom u_rom (
    .num  (num),
    .col  (c_n),
    .word (white)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Request capture, only on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q   <= '0;
      rgb_q   <= '0;
      blank_q <= 1'b0;
    end else if (load) begin
      dig_q   <= digits;
      rgb_q   <= digit_color;
      blank_q <= blank_lz;
    end
  end

  // Position counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q       <= '0;
      c_q       <= '0;
      col_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      col_data  <= '0;
      col_addr  <= '0;
    end else begin
      d_q       <= d_n;
      c_q       <= c_n;
      col_valid <= (state_n == STREAM);
      busy      <= (state_n == STREAM);
      done      <= (state_n == DONE);
      if (load) begin
        col_data <= word_n;
        col_addr <= base_col;
      end else if (step) begin
        col_data <= word_n;
        col_addr <= col_addr + AW'(1);
      end else if (state_n != STREAM) begin
        col_data <= '0;
      end
    end
  end

endmodule
